cdc_fifo_read_ctrl: RTL and testbench

//  Read-domain pointer/flag controller for the async CDC FIFO, successor to the single-bit-compare read state.

---
 rtl/cdc_fifo_read_ctrl.sv | 95 +++++++++
 tb/tb_cdc_fifo_read_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cdc_fifo_read_ctrl.sv
// ============================================================================
// Module  : cdc_fifo_read_ctrl
// Purpose : Read-domain pointer/flag controller for the async CDC FIFO with an
//           internal write-pointer synchroniser, wrap bit, fill level and flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cdc_fifo_read_ctrl #(
  parameter int ADDRESS_WIDTH      = 4,
  parameter int SYNC_STAGES        = 2,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     increment,
  input  logic [ADDRESS_WIDTH:0]   write_pointer_gray,
  output logic [ADDRESS_WIDTH-1:0] read_address,
  output logic [ADDRESS_WIDTH:0]   read_pointer_gray,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [ADDRESS_WIDTH:0]   level,
  output logic                     underflow
);

  localparam int                 c_PW       = ADDRESS_WIDTH + 1;
  localparam logic [c_PW-1:0]    c_AE_LEVEL = c_PW'(ALMOST_EMPTY_LEVEL);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("cdc_fifo_read_ctrl: SYNC_STAGES must be >= 2");
    end
    if (ALMOST_EMPTY_LEVEL < 0 || ALMOST_EMPTY_LEVEL > (1 << ADDRESS_WIDTH)) begin : g_bad_ae_level
      $error("cdc_fifo_read_ctrl: ALMOST_EMPTY_LEVEL out of range");
    end
  endgenerate

  logic [c_PW-1:0] r_sync [SYNC_STAGES];
  logic [c_PW-1:0] r_rptr_bin;
  logic [c_PW-1:0] r_rptr_gray;
  logic            r_underflow;

  logic [c_PW-1:0] w_wptr_bin;
  logic [c_PW-1:0] w_rptr_next;
  logic [c_PW-1:0] w_level;
  logic            w_empty;
  logic            w_pop;

  // Only the last synchroniser stage is ever decoded; earlier stages may be metastable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= write_pointer_gray;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  always_comb begin
    w_wptr_bin          = '0;
    w_wptr_bin[c_PW-1]  = r_sync[SYNC_STAGES-1][c_PW-1];
    for (int i = c_PW - 2; i >= 0; i--) begin
      w_wptr_bin[i] = w_wptr_bin[i+1] ^ r_sync[SYNC_STAGES-1][i];
    end
  end

  assign w_empty     = (w_wptr_bin == r_rptr_bin);
  assign w_level     = w_wptr_bin - r_rptr_bin;
  assign w_pop       = increment & ~w_empty;
  assign w_rptr_next = r_rptr_bin + c_PW'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rptr_bin  <= '0;
      r_rptr_gray <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= increment & w_empty;
      if (w_pop) begin
        r_rptr_bin  <= w_rptr_next;
        r_rptr_gray <= w_rptr_next ^ (w_rptr_next >> 1);
      end
    end
  end

  assign read_address      = r_rptr_bin[ADDRESS_WIDTH-1:0];
  assign read_pointer_gray = r_rptr_gray;
  assign empty             = w_empty;
  assign level             = w_level;
  assign almost_empty      = (w_level <= c_AE_LEVEL);
  assign underflow         = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_cdc_fifo_read_ctrl.sv
// ============================================================================
// Module  : tb_cdc_fifo_read_ctrl
// Purpose : Directed self-checking bench for cdc_fifo_read_ctrl (AW=4, SYNC=2).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdc_fifo_read_ctrl;

  logic       clock;
  logic       reset;
  logic       increment;
  logic [4:0] write_pointer_gray;
  logic [3:0] read_address;
  logic [4:0] read_pointer_gray;
  logic       empty;
  logic       almost_empty;
  logic [4:0] level;
  logic       underflow;

  int compared   = 0;
  int mismatched = 0;

  cdc_fifo_read_ctrl #(
    .ADDRESS_WIDTH      (4),
    .SYNC_STAGES        (2),
    .ALMOST_EMPTY_LEVEL (2)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .increment          (increment),
    .write_pointer_gray (write_pointer_gray),
    .read_address       (read_address),
    .read_pointer_gray  (read_pointer_gray),
    .empty              (empty),
    .almost_empty       (almost_empty),
    .level              (level),
    .underflow          (underflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"},  32'(empty),             32'd1);
    check({tag, "_ae"},     32'(almost_empty),      32'd1);
    check({tag, "_level"},  32'(level),             32'd0);
    check({tag, "_raddr"},  32'(read_address),      32'd0);
    check({tag, "_rgray"},  32'(read_pointer_gray), 32'd0);
    check({tag, "_uflow"},  32'(underflow),         32'd0);
  endtask

  initial begin
    logic [4:0] prev_gray;

    reset              = 1'b1;
    increment          = 1'b0;
    write_pointer_gray = '0;

    // Reset held while inputs toggle
    @(negedge clock);
    increment = 1'b1; write_pointer_gray = gray(5'd3);
    @(negedge clock);
    increment = 1'b0; write_pointer_gray = gray(5'd7);
    @(negedge clock);
    check_reset_outputs("rst_hold");
    write_pointer_gray = '0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("rst_release");

    // Synchroniser latency: write pointer change visible after exactly 2 edges
    write_pointer_gray = gray(5'd1);
    @(negedge clock);
    check("lat_edge1_empty", 32'(empty), 32'd1);
    check("lat_edge1_level", 32'(level), 32'd0);
    @(negedge clock);
    check("lat_edge2_empty", 32'(empty), 32'd0);
    check("lat_edge2_level", 32'(level), 32'd1);

    // Full FIFO then drain 16 entries across the address wrap
    write_pointer_gray = 5'b11000;
    repeat (2) @(negedge clock);
    check("full_level", 32'(level), 32'd16);
    check("full_empty", 32'(empty), 32'd0);
    check("full_ae",    32'(almost_empty), 32'd0);
    increment = 1'b1;
    prev_gray = read_pointer_gray;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d_level", i), 32'(level), 32'(16 - i));
      check($sformatf("drain%0d_raddr", i), 32'(read_address), 32'(i % 16));
      @(negedge clock);
      check($sformatf("drain%0d_gray", i), 32'(read_pointer_gray), 32'(gray(5'(i + 1))));
      check($sformatf("drain%0d_gray_1bit", i), 32'($countones(prev_gray ^ read_pointer_gray)), 32'd1);
      prev_gray = read_pointer_gray;
    end
    increment = 1'b0;
    check("drained_empty", 32'(empty),             32'd1);
    check("drained_level", 32'(level),             32'd0);
    check("drained_raddr", 32'(read_address),      32'd0);
    check("drained_gray",  32'(read_pointer_gray), 32'b11000);
    check("drained_uflow", 32'(underflow),         32'd0);

    // Underflow: three pops while empty, pulse lags by one cycle
    @(negedge clock);
    check("uf_before", 32'(underflow), 32'd0);
    increment = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("uf%0d_pulse", i), 32'(underflow),         32'd1);
      check($sformatf("uf%0d_raddr", i), 32'(read_address),      32'd0);
      check($sformatf("uf%0d_gray", i),  32'(read_pointer_gray), 32'b11000);
    end
    increment = 1'b0;
    @(negedge clock);
    check("uf_after", 32'(underflow), 32'd0);
    check("uf_after_empty", 32'(empty), 32'd1);

    // Almost-empty threshold crossing in both directions
    write_pointer_gray = gray(5'd19);
    repeat (2) @(negedge clock);
    check("ae_l3_level", 32'(level),        32'd3);
    check("ae_l3_flag",  32'(almost_empty), 32'd0);
    increment = 1'b1;
    @(negedge clock);
    increment = 1'b0;
    check("ae_pop_level", 32'(level),        32'd2);
    check("ae_pop_flag",  32'(almost_empty), 32'd1);
    check("ae_pop_raddr", 32'(read_address), 32'd1);
    write_pointer_gray = gray(5'd20);
    @(negedge clock);
    check("ae_wr1_level", 32'(level),        32'd2);
    check("ae_wr1_flag",  32'(almost_empty), 32'd1);
    @(negedge clock);
    check("ae_wr2_level", 32'(level),        32'd3);
    check("ae_wr2_flag",  32'(almost_empty), 32'd0);

    // Reset mid-drain with level 5 and read pointer 7
    reset = 1'b1;
    write_pointer_gray = '0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    write_pointer_gray = gray(5'd12);
    repeat (2) @(negedge clock);
    check("mid_level12", 32'(level), 32'd12);
    increment = 1'b1;
    repeat (7) @(negedge clock);
    increment = 1'b0;
    check("mid_level5", 32'(level),        32'd5);
    check("mid_raddr7", 32'(read_address), 32'd7);
    check("mid_gray7",  32'(read_pointer_gray), 32'(gray(5'd7)));
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    @(negedge clock);
    write_pointer_gray = '0;
    reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("rst_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
